mips32_fetch_unit: RTL and testbench

Instruction-fetch stage of the mips32 pipeline: owns the program counter, issues word fetches to instruction memory over a request/ready handshake, and drives the PC+4/instruction pair consumed by the IF/ID pipeline register. Handles hazard-unit stalls with a one-entry hold buffer. Handles branch/jump redirects from later stages by flushing to a NOP bubble.

---
 rtl/mips32_pkg.sv | 20 ++
 rtl/mips32_fetch_unit_if.sv | 13 +
 rtl/mips32_fetch_hold_buf.sv | 34 +++
 rtl/mips32_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_mips32_fetch_unit.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips32_pkg.sv
// Shared mips32 definitions: fetch FSM states, NOP encoding, default reset PC.
package mips32_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP = 32'h0000_0000;
   localparam logic [XLEN-1:0] INST_BYTES = 32'd4;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } fetchState_t;

   // Sequential fetch address; modulo 2^32 so 32'hFFFF_FFFC wraps to 0.
   function automatic logic [XLEN-1:0] nextPc(input logic [XLEN-1:0] pc);
      return XLEN'(pc + INST_BYTES);
   endfunction

endpackage

// File: rtl/mips32_fetch_unit_if.sv
// Instruction-memory request/ready channel between fetch (master) and imem (slave).
interface mips32_fetch_unit_if;
   import mips32_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready;
   logic [XLEN-1:0] imem_rdata;

   modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);

endinterface

// File: rtl/mips32_fetch_hold_buf.sv
// One-entry buffer parking a fetched word and its next-PC while the pipeline is stalled.
module mips32_fetch_hold_buf
   import mips32_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            drain,
   input  logic            clear,
   input  logic [XLEN-1:0] instIn,
   input  logic [XLEN-1:0] pcIn,
   output logic            full,
   output logic [XLEN-1:0] holdInst,
   output logic [XLEN-1:0] holdPc
);

   // Clear (redirect) wins over load; payload is left stale once emptied.
   always_ff @(posedge clk) begin
      if (rst) begin
         full     <= 1'b0;
         holdInst <= NOP;
         holdPc   <= '0;
      end else if (clear) begin
         full <= 1'b0;
      end else if (load) begin
         full     <= 1'b1;
         holdInst <= instIn;
         holdPc   <= pcIn;
      end else if (drain) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/mips32_fetch_unit.sv
// mips32 instruction-fetch stage: PC, imem handshake, stall hold buffer, redirect flush.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirects raise sticky fetch_exc and park.
module mips32_fetch_unit
   import mips32_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
)
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stall,
   input  logic                       branch_taken,
   input  logic [XLEN-1:0]            branch_target,
   mips32_fetch_unit_if.master        imem,
   output logic [XLEN-1:0]            pc_out,
   output logic [XLEN-1:0]            inst_out,
   output logic                       valid_out
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic                       fetch_exc
`endif
);

   fetchState_t     state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pcPlus4;
   logic [XLEN-1:0] redirectPc;
   logic            redirectOk;
   logic            parked;
   logic            holdLoad;
   logic            holdDrain;
   logic            holdClear;
   logic            holdFull;
   logic [XLEN-1:0] holdInst;
   logic [XLEN-1:0] holdPc;

   // Next-address arithmetic and hold-buffer control derived from current state.
   always_comb begin
      pcPlus4    = nextPc(pc);
      redirectPc = branch_target & ~XLEN'(32'h3);
      redirectOk = 1'b1;
      parked     = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      redirectOk = (branch_target[1:0] == 2'b00);
      parked     = fetch_exc;
`endif
      holdLoad  = (state == REQ) && imem.imem_ready && stall && !branch_taken;
      holdDrain = (state == HOLD) && !stall && !branch_taken;
      holdClear = branch_taken;
   end

   mips32_fetch_hold_buf u_holdBuf (
      .clk      (clk),
      .rst      (rst),
      .load     (holdLoad),
      .drain    (holdDrain),
      .clear    (holdClear),
      .instIn   (imem.imem_rdata),
      .pcIn     (pcPlus4),
      .full     (holdFull),
      .holdInst (holdInst),
      .holdPc   (holdPc)
   );

   // Fetch FSM with registered request and IF/ID outputs; redirect beats stall and ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= BOOT;
         pc             <= RESET_PC;
         pc_out         <= '0;
         inst_out       <= NOP;
         valid_out      <= 1'b0;
         imem.imem_req  <= 1'b0;
         imem.imem_addr <= RESET_PC;
`ifdef FETCH_ALIGN_CHECK_EN
         fetch_exc      <= 1'b0;
`endif
      end else if (branch_taken) begin
         inst_out  <= NOP;
         valid_out <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
         fetch_exc <= !redirectOk;
`endif
         if (redirectOk) begin
            pc             <= redirectPc;
            state          <= REQ;
            imem.imem_req  <= 1'b1;
            imem.imem_addr <= redirectPc;
         end else begin
            state         <= BOOT;
            imem.imem_req <= 1'b0;
         end
      end else begin
         unique case (state)
            BOOT: begin
               if (!stall) begin
                  inst_out  <= NOP;
                  valid_out <= 1'b0;
               end
               if (!parked) begin
                  state          <= REQ;
                  imem.imem_req  <= 1'b1;
                  imem.imem_addr <= pc;
               end
            end
            REQ: begin
               if (imem.imem_ready) begin
                  pc             <= pcPlus4;
                  imem.imem_addr <= pcPlus4;
                  if (stall) begin
                     state         <= HOLD;
                     imem.imem_req <= 1'b0;
                  end else begin
                     pc_out    <= pcPlus4;
                     inst_out  <= imem.imem_rdata;
                     valid_out <= 1'b1;
                  end
               end else if (!stall) begin
                  inst_out  <= NOP;
                  valid_out <= 1'b0;
               end
            end
            HOLD: begin
               if (!stall) begin
                  state          <= REQ;
                  imem.imem_req  <= 1'b1;
                  imem.imem_addr <= pc;
                  if (holdFull) begin
                     pc_out    <= holdPc;
                     inst_out  <= holdInst;
                     valid_out <= 1'b1;
                  end else begin
                     inst_out  <= NOP;
                     valid_out <= 1'b0;
                  end
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_mips32_fetch_unit.sv
// Scoreboard bench for mips32_fetch_unit: fetch-stream reference model + output monitor.
module tb_mips32_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] SALT     = 32'hA5A5_A5A5;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } item_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic [31:0] pc_out;
   logic [31:0] inst_out;
   logic        valid_out;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        fetch_exc;
`endif

   mips32_fetch_unit_if imem ();

   mips32_fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem          (imem),
      .pc_out        (pc_out),
      .inst_out      (inst_out),
      .valid_out     (valid_out)
`ifdef FETCH_ALIGN_CHECK_EN
      ,
      .fetch_exc     (fetch_exc)
`endif
   );

   always #5 clk = ~clk;

   // Memory content is a function of the address so every word is identifiable.
   assign imem.imem_rdata = imem.imem_addr ^ SALT;

   int    checks = 0;
   int    passes = 0;
   item_t expQ[$];

   // Fetch-stream model state (driver side)
   logic        expReq   = 1'b0;
   logic [31:0] expFetch = RESET_PC;
   logic        boot     = 1'b1;
   logic        parked   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Check request state seen since the last edge, drive one cycle, advance the model.
   task automatic step(input logic r, input logic s, input logic rdy, input logic br,
                       input logic [31:0] tgt);
      logic  mis;
      logic  hs;
      item_t it;
      chk("imem_req", 32'(imem.imem_req), 32'(expReq));
      if (expReq) chk("imem_addr", imem.imem_addr, expFetch);
      rst              = r;
      stall            = s;
      imem.imem_ready  = rdy;
      branch_taken     = br;
      branch_target    = tgt;
      mis = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      mis = (tgt[1:0] != 2'b00);
`endif
      hs = !r && !br && expReq && rdy;
      if (r) begin
         expQ.delete();
         expFetch = RESET_PC;
         expReq   = 1'b0;
         boot     = 1'b1;
         parked   = 1'b0;
      end else if (br) begin
         expQ.delete();
         if (mis) begin
            parked = 1'b1;
            expReq = 1'b0;
         end else begin
            parked   = 1'b0;
            boot     = 1'b0;
            expFetch = tgt & ~32'h3;
            expReq   = 1'b1;
         end
      end else begin
         if (hs) begin
            it.pc   = expFetch + 32'd4;
            it.inst = expFetch ^ SALT;
            expQ.push_back(it);
            expFetch = expFetch + 32'd4;
         end
         if (parked) expReq = 1'b0;
         else if (boot) begin
            boot   = 1'b0;
            expReq = 1'b1;
         end else expReq = !(s && expQ.size() > 0);
      end
      @(negedge clk);
   endtask

   // Monitor: after each edge derive the expected IF/ID registers and compare.
   logic [31:0] ePc = 32'h0;
   logic [31:0] eInst = 32'h0;
   logic        eValid = 1'b0;
   logic        eExc = 1'b0;

   always @(posedge clk) begin : monitor
      item_t it;
      #1;
      if (rst) begin
         ePc = 32'h0; eInst = 32'h0; eValid = 1'b0; eExc = 1'b0;
         chk("reset_imem_addr", imem.imem_addr, RESET_PC);
      end else if (branch_taken) begin
         eInst  = 32'h0;
         eValid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
         eExc = (branch_target[1:0] != 2'b00);
`endif
      end else if (!stall) begin
         if (expQ.size() > 0) begin
            it     = expQ.pop_front();
            ePc    = it.pc;
            eInst  = it.inst;
            eValid = 1'b1;
         end else begin
            eInst  = 32'h0;
            eValid = 1'b0;
         end
      end
      chk("pc_out", pc_out, ePc);
      chk("inst_out", inst_out, eInst);
      chk("valid_out", 32'(valid_out), 32'(eValid));
`ifdef FETCH_ALIGN_CHECK_EN
      chk("fetch_exc", 32'(fetch_exc), 32'(eExc));
`endif
   end

   initial begin
      imem.imem_ready = 1'b0;
      @(negedge clk);
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);                // BOOT cycle
      chk("first_req", 32'(imem.imem_req), 32'h1);
      chk("first_addr", imem.imem_addr, RESET_PC);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);                // fetch 0
      chk("first_pc_out", pc_out, 32'h4);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);                // fetch 4
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);     // wait on 8
      chk("wait_addr", imem.imem_addr, 32'h8);
      chk("wait_valid", 32'(valid_out), 32'h0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);                // fetch 8
      chk("late_pc_out", pc_out, 32'hC);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);                // fetch 12
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);                // fetch 16 under stall
      repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("hold_pc_frozen", pc_out, 32'h10);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);                // release
      chk("release_pc_out", pc_out, 32'h14);
      chk("release_inst", inst_out, 32'h10 ^ SALT);
      chk("release_next_addr", imem.imem_addr, 32'h14);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);                // fetch 20
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);              // redirect + stall + ready
      chk("redir_bubble", 32'(valid_out), 32'h0);
      chk("redir_addr", imem.imem_addr, 32'h100);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);                // fetch 0x100
      chk("redir_pc_out", pc_out, 32'h104);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);                // fetch 0xFFFFFFFC
      chk("wrap_pc_out", pc_out, 32'h0);
      chk("wrap_addr", imem.imem_addr, 32'h0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("misalign_exc", 32'(fetch_exc), 32'h1);
      chk("misalign_no_req", 32'(imem.imem_req), 32'h0);
`else
      chk("misalign_addr", imem.imem_addr, 32'h100);
`endif
      repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
      chk("realign_addr", imem.imem_addr, 32'h200);
      repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);

      for (int i = 0; i < 1500; i++) begin
         logic        s;
         logic        rdy;
         logic        br;
         logic        r;
         logic [31:0] t;
         s   = ($urandom_range(0, 99) < 30);
         rdy = ($urandom_range(0, 99) < 65);
         br  = ($urandom_range(0, 99) < 6);
         t   = $urandom;
         if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
         if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
         r   = (i == 700) || (i == 701);
         step(r, s, rdy, br, t);
      end

      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h300);
      repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      chk("queue_drained", 32'(expQ.size()), 32'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
